aud_trace_rx: RTL and testbench

Branch-trace receiver for the AUD debug port. Samples AUDCK/AUDSYNC/AUDATA driven by the target in branch-trace mode, decodes header and address nibbles, reconstructs compressed branch addresses, and buffers complete trace records in a FIFO. The FIFO is drained by the aud_core register file over a valid/ready stream. It sits between the AUD pins and aud_core, alongside the RMM path, and shares its `clk_sys_i` domain.

---
 rtl/aud_trace_rx.sv | 180 ++++++++++++++++++
 tb/tb_aud_trace_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_trace_rx.sv
// aud_trace_rx
//   Branch-trace receiver for the AUD debug port. Synchronises AUDCK/AUDSYNC/
//   AUDATA into clk_sys_i, decodes header/address nibbles, rebuilds compressed
//   branch addresses against the previous address and queues finished records
//   in a FIFO drained by aud_core over a valid/ready stream.
//
// Ports
//   clk_sys_i, rst_n_i           system clock, async active-low reset
//   aud_ck_i, aud_nsync_i        AUDCK / AUDSYNC pins (asynchronous)
//   aud_data_i[3:0]              AUDATA nibble
//   en_i                         receiver enable
//   clr_i                        synchronous clear (FIFO, counters, error, prev addr)
//   trc_valid_o / trc_ready_i    head-record handshake
//   trc_addr_o[31:0], trc_type_o head record contents
//   fifo_level_o[LVL_W-1:0]      stored record count
//   ovf_cnt_o[15:0]              dropped record count (saturating)
//   err_o                        sticky protocol error
module aud_trace_rx #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = 5
) (
    input  logic             clk_sys_i,
    input  logic             rst_n_i,
    input  logic             aud_ck_i,
    input  logic             aud_nsync_i,
    input  logic [3:0]       aud_data_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             trc_valid_o,
    input  logic             trc_ready_i,
    output logic [31:0]      trc_addr_o,
    output logic [1:0]       trc_type_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic [15:0]      ovf_cnt_o,
    output logic             err_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PUSH} state_t;

    // ---------------- input synchronisers ----------------
    logic [2:0] r_ck_sync;
    logic [1:0] r_ns_sync;
    logic [3:0] r_dat_s1, r_dat_s2;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ck_sync <= '0;
            r_ns_sync <= '0;
            r_dat_s1  <= '0;
            r_dat_s2  <= '0;
        end else begin
            r_ck_sync <= {r_ck_sync[1:0], aud_ck_i};
            r_ns_sync <= {r_ns_sync[0], aud_nsync_i};
            r_dat_s1  <= aud_data_i;
            r_dat_s2  <= r_dat_s1;
        end
    end

    logic w_rise, w_hdr, w_pay;
    assign w_rise = r_ck_sync[1] & ~r_ck_sync[2];
    assign w_hdr  = w_rise & ~r_ns_sync[1];
    assign w_pay  = w_rise &  r_ns_sync[1];

    // ---------------- message FSM ----------------
    state_t      r_state;
    logic [1:0]  r_type;
    logic [1:0]  r_len;
    logic [3:0]  r_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_prev;
    logic        r_err;

    // Nibbles enter at the top of r_shift, so after L nibbles the payload sits
    // in the upper 4L bits with the first (least significant) nibble lowest.
    logic [5:0]  w_nbits;
    logic [31:0] w_keep_mask;
    logic [31:0] w_new_addr;

    always_comb begin
        w_nbits     = 6'd4 << r_len;
        w_keep_mask = (w_nbits == 6'd32) ? 32'h0000_0000 : (32'hFFFF_FFFF << w_nbits);
        w_new_addr  = (r_prev & w_keep_mask) | (r_shift >> (6'd32 - w_nbits));
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_type  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_prev  <= '0;
            r_err   <= 1'b0;
        end else if (clr_i) begin
            r_state <= S_IDLE;
            r_prev  <= '0;
            r_err   <= 1'b0;
        end else if (!en_i) begin
            r_state <= S_IDLE;
        end else begin
            if (r_state == S_PUSH)
                r_prev <= w_new_addr;
            // A header is taken in every state; in CAPTURE it aborts the
            // partial message, and a reserved type is flagged right away.
            if (w_hdr) begin
                r_state <= S_CAPTURE;
                r_type  <= r_dat_s2[3:2];
                r_len   <= r_dat_s2[1:0];
                r_cnt   <= 4'd1 << r_dat_s2[1:0];
                if (r_state == S_CAPTURE || r_dat_s2[3:2] == 2'b11)
                    r_err <= 1'b1;
            end else begin
                case (r_state)
                    S_CAPTURE: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_PUSH;
                        end else if (w_pay) begin
                            r_shift <= {r_dat_s2, r_shift[31:4]};
                            r_cnt   <= r_cnt - 4'd1;
                        end
                    end
                    S_PUSH:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- record FIFO ----------------
    logic [33:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr, r_rd;
    logic [LVL_W-1:0] r_level;
    logic [15:0]      r_ovf;
    logic             w_push, w_valid, w_full, w_pop, w_wr;

    assign w_push  = (r_state == S_PUSH) && (r_type != 2'b11) && en_i && !clr_i;
    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_pop   = w_valid && trc_ready_i && !clr_i;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= '0;
        end else if (clr_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= '0;
        end else begin
            if (w_wr)
                r_wr <= r_wr + PTR_W'(1);
            if (w_pop)
                r_rd <= r_rd + PTR_W'(1);
            if (w_push && !w_wr && r_ovf != 16'hFFFF)
                r_ovf <= r_ovf + 16'd1;
            if (w_wr && !w_pop)
                r_level <= r_level + LVL_W'(1);
            else if (!w_wr && w_pop)
                r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (w_wr)
            r_mem[r_wr] <= {r_type, w_new_addr};
    end

    assign trc_valid_o  = w_valid;
    assign trc_addr_o   = w_valid ? r_mem[r_rd][31:0]  : '0;
    assign trc_type_o   = w_valid ? r_mem[r_rd][33:32] : '0;
    assign fifo_level_o = r_level;
    assign ovf_cnt_o    = r_ovf;
    assign err_o        = r_err;

endmodule

// File: tb/tb_aud_trace_rx.sv
module tb_aud_trace_rx;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = 5;

    logic             clk_sys = 1'b0;
    logic             rst_n;
    logic             aud_ck, aud_nsync;
    logic [3:0]       aud_data;
    logic             en, clr, trc_ready;
    logic             trc_valid;
    logic [31:0]      trc_addr;
    logic [1:0]       trc_type;
    logic [LVL_W-1:0] fifo_level;
    logic [15:0]      ovf_cnt;
    logic             err;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk_sys = ~clk_sys;

    aud_trace_rx #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk_sys_i   (clk_sys),
        .rst_n_i     (rst_n),
        .aud_ck_i    (aud_ck),
        .aud_nsync_i (aud_nsync),
        .aud_data_i  (aud_data),
        .en_i        (en),
        .clr_i       (clr),
        .trc_valid_o (trc_valid),
        .trc_ready_i (trc_ready),
        .trc_addr_o  (trc_addr),
        .trc_type_o  (trc_type),
        .fifo_level_o(fifo_level),
        .ovf_cnt_o   (ovf_cnt),
        .err_o       (err)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] m_prev;
    int unsigned m_ovf;
    logic        m_err;

    task automatic model_clear();
        exp_q.delete();
        m_prev = '0;
        m_ovf  = 0;
        m_err  = 1'b0;
    endtask

    // A message of L nibbles replaces the low 4L bits of the previous address.
    task automatic model_msg(input logic [1:0] typ, input logic [1:0] len, input logic [31:0] val);
        longint unsigned base, newp;
        rec_t r;
        base   = 64'd1 << (4 * (1 << len));
        newp   = (longint'(m_prev) / base) * base + (longint'(val) % base);
        m_prev = newp[31:0];
        if (typ == 2'b11) begin
            m_err = 1'b1;
        end else if (exp_q.size() < DEPTH) begin
            r.addr = m_prev;
            r.typ  = typ;
            exp_q.push_back(r);
        end else if (m_ovf < 16'hFFFF) begin
            m_ovf++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One AUD nibble: data set while AUDCK low, 2 cycles setup, 3 cycles high.
    task automatic nib(input logic ns, input logic [3:0] d);
        @(negedge clk_sys);
        aud_nsync = ns;
        aud_data  = d;
        repeat (2) @(negedge clk_sys);
        aud_ck = 1'b1;
        repeat (3) @(negedge clk_sys);
        aud_ck = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] typ, input logic [1:0] len, input logic [31:0] val);
        nib(1'b0, {typ, len});
        for (int unsigned k = 0; k < (1 << len); k++)
            nib(1'b1, val[4*k +: 4]);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic pulse_clr();
        @(negedge clk_sys);
        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0;
    endtask

    task automatic pop_check(input string nm, input logic [31:0] ea, input logic [1:0] et);
        int unsigned n = 0;
        while (!trc_valid && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk({nm, " valid"}, 32'(trc_valid), 32'd1);
        chk({nm, " addr"}, trc_addr, ea);
        chk({nm, " type"}, 32'(trc_type), 32'(et));
        trc_ready = 1'b1;
        @(negedge clk_sys);
        trc_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  typ;
        logic [1:0]  len;
        logic [31:0] val;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int unsigned n;
        rec_t        r;
        logic [1:0]  rt, rl;
        logic [31:0] rv;

        tbl[0] = '{typ: 2'd1, len: 2'd3, val: 32'hDEADBEEF, exp_addr: 32'hDEADBEEF};
        tbl[1] = '{typ: 2'd2, len: 2'd1, val: 32'h00000034, exp_addr: 32'hDEADBE34};
        tbl[2] = '{typ: 2'd0, len: 2'd0, val: 32'h00000007, exp_addr: 32'hDEADBE37};
        tbl[3] = '{typ: 2'd1, len: 2'd2, val: 32'h0000CAFE, exp_addr: 32'hDEADCAFE};
        tbl[4] = '{typ: 2'd2, len: 2'd0, val: 32'h00000000, exp_addr: 32'hDEADCAF0};
        tbl[5] = '{typ: 2'd0, len: 2'd3, val: 32'h12345678, exp_addr: 32'h12345678};

        rst_n = 1'b0; aud_ck = 1'b0; aud_nsync = 1'b1; aud_data = '0;
        en = 1'b1; clr = 1'b0; trc_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // reset state
        chk("rst valid", 32'(trc_valid), 32'd0);
        chk("rst addr", trc_addr, 32'd0);
        chk("rst type", 32'(trc_type), 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst ovf", 32'(ovf_cnt), 32'd0);
        chk("rst err", 32'(err), 32'd0);

        // full-address message with exact latency on the last nibble
        nib(1'b0, 4'b0111);
        nib(1'b1, 4'hF); nib(1'b1, 4'hE); nib(1'b1, 4'hE); nib(1'b1, 4'hB);
        nib(1'b1, 4'hD); nib(1'b1, 4'hA); nib(1'b1, 4'hE);
        @(negedge clk_sys);
        aud_data = 4'hD;
        repeat (2) @(negedge clk_sys);
        aud_ck = 1'b1;
        @(posedge clk_sys);                 // edge N
        repeat (3) @(posedge clk_sys);
        #1;
        chk("lat N+3 valid", 32'(trc_valid), 32'd0);
        chk("lat N+3 level", 32'(fifo_level), 32'd0);
        @(posedge clk_sys);
        #1;
        chk("lat N+4 valid", 32'(trc_valid), 32'd1);
        chk("lat N+4 level", 32'(fifo_level), 32'd1);
        aud_ck = 1'b0;
        @(negedge clk_sys);
        pop_check("full addr", 32'hDEADBEEF, 2'd1);

        // compressed address against the previous message
        send_msg(2'd2, 2'd1, 32'h00000034);
        settle();
        pop_check("compressed", 32'hDEADBE34, 2'd2);

        // table-driven messages, queued then drained in order
        pulse_clr();
        foreach (tbl[i]) send_msg(tbl[i].typ, tbl[i].len, tbl[i].val);
        settle();
        chk("tbl level", 32'(fifo_level), 32'd6);
        foreach (tbl[i]) pop_check($sformatf("tbl%0d", i), tbl[i].exp_addr, tbl[i].typ);
        chk("tbl err", 32'(err), 32'd0);

        // mid-message abort by a new header
        pulse_clr();
        nib(1'b0, 4'b0011);
        nib(1'b1, 4'h1); nib(1'b1, 4'h2); nib(1'b1, 4'h3);
        send_msg(2'd0, 2'd0, 32'h5);
        settle();
        chk("abort err", 32'(err), 32'd1);
        chk("abort level", 32'(fifo_level), 32'd1);
        pop_check("abort rec", 32'h00000005, 2'd0);

        // overflow: DEPTH+3 messages with no consumer
        pulse_clr();
        for (int unsigned k = 0; k < DEPTH + 3; k++)
            send_msg(2'(k % 3), 2'd0, 32'(k % 16));
        settle();
        chk("ovf level", 32'(fifo_level), 32'd16);
        chk("ovf count", 32'(ovf_cnt), 32'd3);
        trc_ready = 1'b1;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            chk($sformatf("drain%0d valid", k), 32'(trc_valid), 32'd1);
            chk($sformatf("drain%0d addr", k), trc_addr, k);
            chk($sformatf("drain%0d type", k), 32'(trc_type), k % 3);
            @(negedge clk_sys);
        end
        trc_ready = 1'b0;
        chk("drain level", 32'(fifo_level), 32'd0);
        chk("drain valid", 32'(trc_valid), 32'd0);

        // reserved type, then clear
        send_msg(2'd3, 2'd0, 32'hA);
        settle();
        chk("rsv level", 32'(fifo_level), 32'd0);
        chk("rsv err", 32'(err), 32'd1);
        chk("rsv ovf kept", 32'(ovf_cnt), 32'd3);
        pulse_clr();
        chk("clr err", 32'(err), 32'd0);
        chk("clr ovf", 32'(ovf_cnt), 32'd0);
        chk("clr level", 32'(fifo_level), 32'd0);

        // disable mid-message, re-enable, valid message
        nib(1'b0, 4'b0111);
        nib(1'b1, 4'h1); nib(1'b1, 4'h2);
        @(negedge clk_sys); en = 1'b0;
        repeat (4) @(negedge clk_sys); en = 1'b1;
        send_msg(2'd1, 2'd3, 32'hABCD1239);
        settle();
        chk("dis level", 32'(fifo_level), 32'd1);
        chk("dis addr", trc_addr, 32'hABCD1239);
        chk("dis err", 32'(err), 32'd0);

        // async reset mid-message
        nib(1'b0, 4'b0111);
        nib(1'b1, 4'h4); nib(1'b1, 4'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(trc_valid), 32'd0);
        chk("arst addr", trc_addr, 32'd0);
        chk("arst level", 32'(fifo_level), 32'd0);
        chk("arst err", 32'(err), 32'd0);
        chk("arst ovf", 32'(ovf_cnt), 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        send_msg(2'd2, 2'd0, 32'h3);
        settle();
        pop_check("post arst", 32'h00000003, 2'd2);

        // randomized batches against the model with a random consumer
        pulse_clr();
        model_clear();
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned m = 0; m < $urandom_range(1, 22); m++) begin
                rt = 2'($urandom_range(0, 3));
                rl = 2'($urandom_range(0, 3));
                rv = $urandom;
                send_msg(rt, rl, rv);
                model_msg(rt, rl, rv);
            end
            settle();
            chk($sformatf("rnd%0d level", b), 32'(fifo_level), exp_q.size());
            chk($sformatf("rnd%0d ovf", b), 32'(ovf_cnt), m_ovf);
            chk($sformatf("rnd%0d err", b), 32'(err), 32'(m_err));
            n = 0;
            while (exp_q.size() > 0 && n < 3000) begin
                trc_ready = 1'($urandom_range(0, 1));
                if (trc_ready && trc_valid) begin
                    r = exp_q.pop_front();
                    chk($sformatf("rnd%0d addr", b), trc_addr, r.addr);
                    chk($sformatf("rnd%0d type", b), 32'(trc_type), 32'(r.typ));
                end
                @(negedge clk_sys);
                n++;
            end
            trc_ready = 1'b0;
            chk($sformatf("rnd%0d left", b), exp_q.size(), 32'd0);
            chk($sformatf("rnd%0d empty", b), 32'(fifo_level), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
